hs_capture_ctrl: RTL and testbench



---
 rtl/hs_capture_ctrl_pkg.sv | 14 +
 rtl/hs_capture_ctrl_sync.sv | 38 +++
 rtl/hs_capture_ctrl.sv | 113 +++++++++++
 tb/tb_hs_capture_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hs_capture_ctrl_pkg.sv
// rtl/hs_capture_ctrl_pkg.sv - shared types for the host capture controller
//
// Holds the handshake FSM state type used by hs_capture_ctrl.
//   ST_IDLE : waiting for a synchronized request with a free holding register
//   ST_ACK  : word captured, ack_out high until the host drops its request

package hs_capture_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } hs_state_e;

endpackage : hs_capture_ctrl_pkg

// File: rtl/hs_capture_ctrl_sync.sv
// rtl/hs_capture_ctrl_sync.sv - multi-flop synchronizer with clock enable
//
// Ports:
//   clk   in            destination clock
//   rstb  in            asynchronous active-low reset, clears every stage
//   ena   in            clock enable; when low the whole chain holds
//   d     in  [WIDTH]   asynchronous input
//   q     out [WIDTH]   output of the last stage, STAGES enabled edges behind d

module hs_capture_ctrl_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else if (ena) begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule : hs_capture_ctrl_sync

// File: rtl/hs_capture_ctrl.sv
// rtl/hs_capture_ctrl.sv - 4-phase req/ack receiver feeding a valid/ready stream
//
// Ports:
//   clk         in             system clock
//   rstb        in             asynchronous active-low reset
//   ena         in             clock enable; when low all state holds
//   req_in      in             asynchronous host request
//   data_in     in  [WIDTH]    host data, bundled with req_in (never synchronized)
//   ack_out     out            registered acknowledge to the host
//   dout        out [WIDTH]    captured word
//   dout_valid  out            dout holds an unconsumed word
//   dout_ready  in             downstream takes dout when valid && ready
//   busy        out            registered, high whenever the FSM is not idle
//   xfer_count  out [CNT_W]    words captured since reset, wraps

module hs_capture_ctrl
  import hs_capture_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             req_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack_out,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_count
);

  hs_state_e state;
  hs_state_e state_nxt;
  logic      req_s;
  logic      buf_free;
  logic      consume;
  logic      capture;

  // Only the strobe crosses domains; data_in is held stable by the host
  // from req rise until it sees ack, so it is sampled directly.
  hs_capture_ctrl_sync #(
    .WIDTH  (1),
    .STAGES (STAGES)
  ) u_req_sync (
    .clk  (clk),
    .rstb (rstb),
    .ena  (ena),
    .d    (req_in),
    .q    (req_s)
  );

  // A full register that is being drained this cycle counts as free, so a
  // consume and a capture can share one edge without losing a word.
  assign buf_free = !dout_valid || dout_ready;
  assign consume  = dout_valid && dout_ready;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        // With the register full the request is simply left unanswered;
        // the host stalls on ack, which is the backpressure path.
        if (req_s && buf_free) begin
          capture   = 1'b1;
          state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ack_out and busy are registered from the next state so they change on
  // the same edge as the state itself.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= ST_IDLE;
      ack_out <= 1'b0;
      busy    <= 1'b0;
    end else if (ena) begin
      state   <= state_nxt;
      ack_out <= (state_nxt == ST_ACK);
      busy    <= (state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      xfer_count <= '0;
    end else if (ena) begin
      if (capture) begin
        dout       <= data_in;
        dout_valid <= 1'b1;
        xfer_count <= xfer_count + CNT_W'(1);
      end else if (consume) begin
        // dout keeps the stale word; only the valid flag drops.
        dout_valid <= 1'b0;
      end
    end
  end

endmodule : hs_capture_ctrl

// File: tb/tb_hs_capture_ctrl.sv
// tb/tb_hs_capture_ctrl.sv - self-checking bench for hs_capture_ctrl

module tb_hs_capture_ctrl;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic       clk = 1'b0;
  logic       rstb = 1'b1;
  logic       ena = 1'b1;
  logic       req_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       dout_ready = 1'b0;

  logic       ack_a, valid_a, busy_a;
  logic [7:0] dout_a;
  logic [7:0] cnt_a;
  logic       ack_b, valid_b, busy_b;
  logic [7:0] dout_b;
  logic [1:0] cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hs_capture_ctrl #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(8)) dut_a (
    .clk(clk), .rstb(rstb), .ena(ena), .req_in(req_in), .data_in(data_in),
    .ack_out(ack_a), .dout(dout_a), .dout_valid(valid_a),
    .dout_ready(dout_ready), .busy(busy_a), .xfer_count(cnt_a)
  );

  hs_capture_ctrl #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(2)) dut_b (
    .clk(clk), .rstb(rstb), .ena(ena), .req_in(req_in), .data_in(data_in),
    .ack_out(ack_b), .dout(dout_b), .dout_valid(valid_b),
    .dout_ready(dout_ready), .busy(busy_b), .xfer_count(cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the request seen by the receiver is req_in delayed
  // by STAGES enabled edges; the receiver holds at most one word.
  int   req_seen[$];
  bit   m_ack = 0;
  bit   m_valid = 0;
  int   m_word = 0;
  int   m_count = 0;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      req_seen = {};
      for (int i = 0; i < STAGES; i++) req_seen.push_back(0);
      m_ack = 0; m_valid = 0; m_word = 0; m_count = 0;
    end else if (ena) begin
      int rs;
      rs = req_seen.pop_front();
      req_seen.push_back(int'(req_in));
      if (m_ack) begin
        if (rs == 0) m_ack = 0;
        if (m_valid && dout_ready) m_valid = 0;
      end else if (rs != 0 && (!m_valid || dout_ready)) begin
        m_word  = int'(data_in);
        m_valid = 1;
        m_count = m_count + 1;
        m_ack   = 1;
      end else if (m_valid && dout_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    check("a_ack",   32'(ack_a),   32'(m_ack));
    check("a_busy",  32'(busy_a),  32'(m_ack));
    check("a_valid", 32'(valid_a), 32'(m_valid));
    check("a_dout",  32'(dout_a),  32'(m_word));
    check("a_count", 32'(cnt_a),   32'(m_count % 256));
    check("b_ack",   32'(ack_b),   32'(m_ack));
    check("b_valid", 32'(valid_b), 32'(m_valid));
    check("b_dout",  32'(dout_b),  32'(m_word));
    check("b_count", 32'(cnt_b),   32'(m_count % 4));
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_ack(input logic level, input string name);
    int n = 0;
    while (ack_a !== level && n < 20) begin
      step();
      n++;
    end
    check(name, 32'(ack_a), 32'(level));
  endtask

  task automatic xfer(input logic [7:0] d);
    data_in = d;
    req_in  = 1'b1;
    wait_ack(1'b1, "xfer_ack_rise");
    req_in  = 1'b0;
  endtask

  task automatic drop_req();
    req_in = 1'b0;
    wait_ack(1'b0, "xfer_ack_fall");
  endtask

  logic [1:0] wrap_exp [5];

  initial begin
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    // Reset with random inputs
    #1 rstb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_in = 1'($urandom); data_in = 8'($urandom); dout_ready = 1'($urandom);
      step();
    end
    check("rst_ack",   32'(ack_a),   32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_dout",  32'(dout_a),  32'd0);
    check("rst_busy",  32'(busy_a),  32'd0);
    check("rst_count", 32'(cnt_a),   32'd0);

    // Single transfer, 3-edge latency each way
    req_in = 1'b0; dout_ready = 1'b1; data_in = 8'hA5;
    rstb = 1'b1;
    step(); step();
    req_in = 1'b1;
    step(); check("single_e1_ack", 32'(ack_a), 32'd0);
    step(); check("single_e2_ack", 32'(ack_a), 32'd0);
    step(); check("single_e3_ack", 32'(ack_a), 32'd1);
    check("single_dout",  32'(dout_a),  32'hA5);
    check("single_valid", 32'(valid_a), 32'd1);
    check("single_count", 32'(cnt_a),   32'd1);
    step(); check("single_valid_pulse", 32'(valid_a), 32'd0);
    req_in = 1'b0;
    step(); check("single_f1_ack", 32'(ack_a), 32'd1);
    step(); check("single_f2_ack", 32'(ack_a), 32'd1);
    step(); check("single_f3_ack", 32'(ack_a), 32'd0);

    // Backpressure
    dout_ready = 1'b0;
    xfer(8'h11);
    drop_req();
    data_in = 8'h22; req_in = 1'b1;
    repeat (6) step();
    check("bp_ack_held", 32'(ack_a),   32'd0);
    check("bp_dout_old", 32'(dout_a),  32'h11);
    check("bp_valid",    32'(valid_a), 32'd1);
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    check("bp_dout_new", 32'(dout_a),  32'h22);
    check("bp_valid2",   32'(valid_a), 32'd1);
    check("bp_ack_rise", 32'(ack_a),   32'd1);
    check("bp_count",    32'(cnt_a),   32'd3);
    drop_req();
    dout_ready = 1'b1;
    step();
    check("bp_drained", 32'(valid_a), 32'd0);

    // ena gating mid-handshake
    data_in = 8'h3C; req_in = 1'b1;
    step();
    ena = 1'b0;
    repeat (5) step();
    check("ena_ack_frozen",  32'(ack_a),  32'd0);
    check("ena_dout_frozen", 32'(dout_a), 32'h22);
    ena = 1'b1;
    step(); check("ena_resume_e2", 32'(ack_a), 32'd0);
    step(); check("ena_resume_e3", 32'(ack_a), 32'd1);
    check("ena_dout",    32'(dout_a), 32'h3C);
    check("ena_count_b", 32'(cnt_b),  32'd0);
    ena = 1'b0; req_in = 1'b0;
    repeat (5) step();
    check("ena_ack_hold",   32'(ack_a),   32'd1);
    check("ena_ready_ign",  32'(valid_a), 32'd1);
    ena = 1'b1;
    wait_ack(1'b0, "ena_ack_fall");

    // Reset mid-transfer
    dout_ready = 1'b0; data_in = 8'h5A; req_in = 1'b1;
    wait_ack(1'b1, "mid_ack_rise");
    check("mid_valid_pre", 32'(valid_a), 32'd1);
    rstb = 1'b0;
    #1;
    check("mid_ack",   32'(ack_a),   32'd0);
    check("mid_valid", 32'(valid_a), 32'd0);
    check("mid_dout",  32'(dout_a),  32'd0);
    check("mid_busy",  32'(busy_a),  32'd0);
    check("mid_count", 32'(cnt_a),   32'd0);
    step(); step();
    rstb = 1'b1;
    step(); check("mid_r1_ack", 32'(ack_a), 32'd0);
    step(); check("mid_r2_ack", 32'(ack_a), 32'd0);
    step(); check("mid_r3_ack", 32'(ack_a), 32'd1);
    check("mid_r_dout",  32'(dout_a), 32'h5A);
    check("mid_r_count", 32'(cnt_a),  32'd1);
    drop_req();

    // Counter wrap on the CNT_W=2 instance
    rstb = 1'b0;
    step();
    rstb = 1'b1; dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      xfer(8'(i + 1));
      check("wrap_count_b", 32'(cnt_b), 32'(wrap_exp[i]));
      check("wrap_count_a", 32'(cnt_a), 32'(i + 1));
      drop_req();
    end
    check("wrap_last_dout", 32'(dout_b), 32'h05);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_hs_capture_ctrl
